// File: rtl/fpu_result_collector.sv
// ============================================================================
// Module      : fpu_result_collector
// Description : Captures {flag_vector,result} pairs from the FPU into a FIFO
//               and presents them to the output pipe sender with valid/ready,
//               tracking end-of-message and completion.
//               Optional feature macro: FPU_RESULT_STICKY_FLAGS_EN
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpu_result_collector #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    res_valid,
    input  logic                    res_last,
    input  logic [DATA_WIDTH-1:0]   result,
    input  logic [7:0]              flag_vector,
    output logic                    res_ready,
    output logic                    rec_valid,
    input  logic                    rec_ready,
    output logic [DATA_WIDTH+7:0]   rec_data,
    output logic                    rec_eom,
    output logic [CNT_W-1:0]        rec_count,
    output logic                    overflow_err,
`ifdef FPU_RESULT_STICKY_FLAGS_EN
    output logic [7:0]              sticky_flags,
`endif
    output logic                    done
);

    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int REC_W   = DATA_WIDTH + 8;
    localparam int ENTRY_W = REC_W + 1;

    localparam logic [PTR_W:0]   c_full_occ = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   c_occ_one  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] c_ptr_one  = PTR_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DRAIN  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [ENTRY_W-1:0]   r_mem [DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [PTR_W:0]       r_occ;
    logic [CNT_W-1:0]     r_rec_count;
    logic                 r_overflow_err;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_accepting;
    logic                 w_push;
    logic                 w_pop;
    logic [ENTRY_W-1:0]   w_head;

    assign w_full      = (r_occ == c_full_occ);
    assign w_empty     = (r_occ == '0);
    assign w_accepting = (r_state == S_IDLE) || (r_state == S_STREAM);
    assign w_push      = res_valid && res_ready;
    assign w_pop       = rec_valid && rec_ready;
    assign w_head      = r_mem[r_rd_ptr];

    // res_ready depends only on registered state, never on rec_ready.
    assign res_ready    = w_accepting && !w_full;
    assign rec_valid    = !w_empty;
    assign rec_data     = rec_valid ? w_head[REC_W-1:0] : '0;
    assign rec_eom      = rec_valid && w_head[REC_W];
    assign rec_count    = r_rec_count;
    assign overflow_err = r_overflow_err;
    assign done         = (r_state == S_DONE);

    // Storage needs no reset: reads are masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {res_last, flag_vector, result};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            if (w_push && !w_pop) begin
                r_occ <= r_occ + c_occ_one;
            end else if (w_pop && !w_push) begin
                r_occ <= r_occ - c_occ_one;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rec_count    <= '0;
            r_overflow_err <= 1'b0;
        end else begin
            if (w_push && (r_rec_count != '1)) begin
                r_rec_count <= r_rec_count + c_cnt_one;
            end
            // A result arriving in DRAIN/DONE is ignored, not an overflow.
            if (res_valid && w_accepting && w_full) begin
                r_overflow_err <= 1'b1;
            end
        end
    end

`ifdef FPU_RESULT_STICKY_FLAGS_EN
    logic [7:0] r_sticky_flags;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sticky_flags <= '0;
        end else if (w_push) begin
            r_sticky_flags <= r_sticky_flags | flag_vector;
        end
    end

    assign sticky_flags = r_sticky_flags;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_push) begin
                    w_state_next = res_last ? S_DRAIN : S_STREAM;
                end
            end
            S_STREAM: begin
                if (w_push && res_last) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_pop && w_head[REC_W]) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_DONE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_fpu_result_collector.sv
// ============================================================================
// Module      : tb_fpu_result_collector
// Description : Self-checking bench for fpu_result_collector against a
//               queue-based reference model. Honours FPU_RESULT_STICKY_FLAGS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fpu_result_collector;

    localparam int DATA_WIDTH = 32;
    localparam int DEPTH      = 8;
    localparam int CNT_W      = 4;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic                  clk;
    logic                  reset;
    logic                  res_valid;
    logic                  res_last;
    logic [DATA_WIDTH-1:0] result;
    logic [7:0]            flag_vector;
    logic                  res_ready;
    logic                  rec_valid;
    logic                  rec_ready;
    logic [DATA_WIDTH+7:0] rec_data;
    logic                  rec_eom;
    logic [CNT_W-1:0]      rec_count;
    logic                  overflow_err;
    logic                  done;
`ifdef FPU_RESULT_STICKY_FLAGS_EN
    logic [7:0]            sticky_flags;
`endif

    fpu_result_collector #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .res_valid    (res_valid),
        .res_last     (res_last),
        .result       (result),
        .flag_vector  (flag_vector),
        .res_ready    (res_ready),
        .rec_valid    (rec_valid),
        .rec_ready    (rec_ready),
        .rec_data     (rec_data),
        .rec_eom      (rec_eom),
        .rec_count    (rec_count),
        .overflow_err (overflow_err),
`ifdef FPU_RESULT_STICKY_FLAGS_EN
        .sticky_flags (sticky_flags),
`endif
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: a message is a stream of records; once its last record
    // is accepted the input is closed, and delivering that record finishes it.
    logic [40:0] mq[$];
    bit          m_closed;
    bit          m_finished;
    bit          m_ovf;
    int          m_cnt;
    logic [7:0]  m_stk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_closed   = 0;
        m_finished = 0;
        m_ovf      = 0;
        m_cnt      = 0;
        m_stk      = '0;
    endtask

    task automatic check_all();
        logic [40:0] head;
        bit          exp_valid;
        exp_valid = (mq.size() != 0);
        head      = exp_valid ? mq[0] : '0;
        chk("res_ready", 64'(res_ready), 64'(!m_closed && mq.size() < DEPTH));
        chk("rec_valid", 64'(rec_valid), 64'(exp_valid));
        chk("rec_data", 64'(rec_data), 64'(head[39:0]));
        chk("rec_eom", 64'(rec_eom), 64'(head[40]));
        chk("rec_count", 64'(rec_count), 64'(m_cnt));
        chk("overflow_err", 64'(overflow_err), 64'(m_ovf));
        chk("done", 64'(done), 64'(m_finished));
`ifdef FPU_RESULT_STICKY_FLAGS_EN
        chk("sticky_flags", 64'(sticky_flags), 64'(m_stk));
`endif
    endtask

    task automatic model_step();
        bit          push;
        bit          pop;
        logic [40:0] h;
        push = res_valid && !m_closed && (mq.size() < DEPTH);
        pop  = (mq.size() != 0) && rec_ready;
        if (res_valid && !m_closed && mq.size() == DEPTH) m_ovf = 1;
        if (pop) begin
            h = mq.pop_front();
            if (h[40]) m_finished = 1;
        end
        if (push) begin
            mq.push_back({res_last, flag_vector, result});
            if (m_cnt < CNT_MAX) m_cnt++;
            m_stk = m_stk | flag_vector;
            if (res_last) m_closed = 1;
        end
    endtask

    // One clock cycle: drive inputs, compare outputs, advance model and DUT.
    task automatic cyc(input logic v, input logic l, input logic [31:0] r,
                       input logic [7:0] f, input logic rr);
        res_valid   = v;
        res_last    = l;
        result      = r;
        flag_vector = f;
        rec_ready   = rr;
        #1;
        check_all();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        res_valid   = 1'b0;
        res_last    = 1'b0;
        result      = '0;
        flag_vector = '0;
        rec_ready   = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [39:0] prev_data;
        bit          prev_stall;

        // 1: single-record message
        do_reset();
        chk("rst_res_ready", 64'(res_ready), 64'd1);
        chk("rst_rec_valid", 64'(rec_valid), 64'd0);
        chk("rst_rec_data", 64'(rec_data), 64'd0);
        cyc(1, 1, 32'h3F800000, 8'h00, 1);
        chk("t1_data", 64'(rec_data), 64'h003F800000);
        chk("t1_eom", 64'(rec_eom), 64'd1);
        cyc(0, 0, 0, 0, 1);
        chk("t1_done", 64'(done), 64'd1);
        chk("t1_count", 64'(rec_count), 64'd1);
        cyc(1, 0, 32'h1234, 0, 1);

        // 2: fill, overflow, then drain in order
        do_reset();
        for (int i = 0; i < DEPTH; i++) cyc(1, 0, 32'(i), 8'(i), 0);
        chk("t2_full", 64'(res_ready), 64'd0);
        cyc(1, 0, 32'hDEAD, 8'hFF, 0);
        chk("t2_ovf", 64'(overflow_err), 64'd1);
        chk("t2_count", 64'(rec_count), 64'd8);
        for (int i = 0; i < DEPTH; i++) begin
            chk("t2_order", 64'(rec_data[31:0]), 64'(i));
            cyc(0, 0, 0, 0, 1);
        end

        // 3: simultaneous push/pop at occupancy 4 across pointer wrap
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1, 0, 32'(10 + i), 0, 0);
        for (int i = 0; i < 10; i++) begin
            chk("t3_order", 64'(rec_data[31:0]), 64'(i < 4 ? 10 + i : 100 + i - 4));
            cyc(1, 0, 32'(100 + i), 0, 1);
        end
        chk("t3_occ", 64'(mq.size()), 64'd4);

        // 4: flags held stable under toggling rec_ready
        do_reset();
        prev_stall = 0;
        prev_data  = '0;
        for (int i = 0; i < 10; i++) begin
            if (prev_stall) chk("t4_hold", 64'(rec_data), 64'(prev_data));
            if (mq.size() != 0) chk("t4_flags", 64'(rec_data[39:32]), 64'h81);
            prev_stall = (mq.size() != 0) && (i % 2 == 0);
            prev_data  = rec_data;
            cyc(i < 5, 0, $urandom, 8'h81, 1'(i % 2));
        end

        // 5: inputs during drain are ignored
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1, i == 2, 32'(i), 0, 0);
        for (int i = 0; i < 4; i++) cyc(1, 0, 32'hBAD, 8'hFF, 0);
        chk("t5_ready", 64'(res_ready), 64'd0);
        chk("t5_ovf", 64'(overflow_err), 64'd0);
        cyc(1, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 1);
        chk("t5_not_done", 64'(done), 64'd0);
        cyc(1, 0, 0, 0, 1);
        chk("t5_done", 64'(done), 64'd1);

        // 6: reset with entries pending, then sticky accumulation
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1, 0, 32'(i), 8'h10, 0);
        do_reset();
        chk("t6_valid", 64'(rec_valid), 64'd0);
        chk("t6_count", 64'(rec_count), 64'd0);
        chk("t6_done", 64'(done), 64'd0);
        chk("t6_ready", 64'(res_ready), 64'd1);
        cyc(1, 0, 1, 8'h04, 1);
        cyc(1, 0, 2, 8'h20, 1);
        cyc(0, 0, 0, 0, 1);
`ifdef FPU_RESULT_STICKY_FLAGS_EN
        chk("t6_sticky", 64'(sticky_flags), 64'h24);
`endif

        // rec_count saturation
        do_reset();
        for (int i = 0; i < CNT_MAX + 5; i++) cyc(1, 0, 32'(i), 0, 1);
        chk("sat_count", 64'(rec_count), 64'(CNT_MAX));

        // randomized messages against the model
        for (int m = 0; m < 8; m++) begin
            do_reset();
            for (int i = 0; i < 80; i++) begin
                cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0),
                    $urandom, 8'($urandom), ($urandom_range(0, 2) != 0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire
